// File: rtl/apple_spawner.sv
// apple_spawner: picks a random free grid cell for the apple via an LFSR and
// a req/ack occupancy query, then publishes its pixel position to the renderer.
module apple_spawner #(
    parameter int          BIT       = 10,
    parameter int          SIZE      = 10,
    parameter int          GRID_W    = 64,
    parameter int          GRID_H    = 48,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          INIT_X    = 320,
    parameter int          INIT_Y    = 240
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_eaten,
    output logic           o_query_req,
    output logic [BIT-1:0] o_query_x,
    output logic [BIT-1:0] o_query_y,
    input  logic           i_query_ack,
    input  logic           i_query_hit,
    output logic [BIT-1:0] o_apple_x,
    output logic [BIT-1:0] o_apple_y,
    output logic           o_apple_valid,
    output logic           o_spawn_done,
    output logic           o_spawn_fail
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, GEN, QUERY} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_lfsr;
    logic [TW-1:0]   r_tries;
    logic [5:0]      w_cx;
    logic [5:0]      w_cy_raw;
    logic [5:0]      w_cy;
    logic [BIT-1:0]  w_px;
    logic [BIT-1:0]  w_py;
    logic            w_ack;
    logic            w_last;

    assign w_cx     = r_lfsr[5:0] & 6'(GRID_W - 1);
    assign w_cy_raw = r_lfsr[11:6];
    // one subtraction folds the 6-bit row into range since GRID_H >= 32
    assign w_cy     = ({1'b0, w_cy_raw} >= 7'(GRID_H)) ? w_cy_raw - 6'(GRID_H) : w_cy_raw;
    assign w_px     = BIT'(w_cx) * BIT'(SIZE);
    assign w_py     = BIT'(w_cy) * BIT'(SIZE);
    assign w_ack    = (r_state == QUERY) && i_query_ack;
    assign w_last   = r_tries >= TW'(MAX_TRIES);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE)
            w_next = i_eaten ? GEN : IDLE;
        else if (r_state == GEN)
            w_next = QUERY;
        else if (r_state == QUERY)
            w_next = !w_ack ? QUERY : (i_query_hit && !w_last) ? GEN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr        <= SEED;
            r_tries       <= '0;
            o_query_req   <= 1'b0;
            o_query_x     <= '0;
            o_query_y     <= '0;
            o_apple_x     <= BIT'(INIT_X);
            o_apple_y     <= BIT'(INIT_Y);
            o_apple_valid <= 1'b1;
            o_spawn_done  <= 1'b0;
            o_spawn_fail  <= 1'b0;
        end else begin
            r_lfsr       <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
            o_spawn_done <= 1'b0;
            o_spawn_fail <= 1'b0;
            if (r_state == IDLE && i_eaten) begin
                o_apple_valid <= 1'b0;
                r_tries       <= '0;
            end
            if (r_state == GEN) begin
                o_query_x   <= w_px;
                o_query_y   <= w_py;
                r_tries     <= r_tries + 1'b1;
                o_query_req <= 1'b1;
            end
            if (w_ack) begin
                o_query_req <= 1'b0;
                if (!i_query_hit || w_last) begin
                    o_apple_x     <= o_query_x;
                    o_apple_y     <= o_query_y;
                    o_apple_valid <= 1'b1;
                    o_spawn_done  <= 1'b1;
                    o_spawn_fail  <= i_query_hit;
                end
            end
        end
    end
endmodule

// File: tb/tb_apple_spawner.sv
// tb_apple_spawner: directed bench with a transaction-level expectation model
// and an LFSR reference; one per-cycle compare process checks all outputs.
module tb_apple_spawner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       eaten = 1'b0;
    logic       ack = 1'b0;
    logic       hit = 1'b0;
    logic       req, done, fail, valid;
    logic [9:0] qx, qy, ax, ay;

    int checks = 0;
    int errors = 0;
    int rises = 0;
    bit chk_en = 1'b0;
    logic req_d = 1'b0;
    int exp_ax, exp_ay, exp_qx, exp_qy;
    bit exp_valid, exp_req, exp_done, exp_fail;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    apple_spawner dut (
        .clk(clk), .rst(rst), .i_eaten(eaten),
        .o_query_req(req), .o_query_x(qx), .o_query_y(qy),
        .i_query_ack(ack), .i_query_hit(hit),
        .o_apple_x(ax), .o_apple_y(ay), .o_apple_valid(valid),
        .o_spawn_done(done), .o_spawn_fail(fail)
    );

    function automatic logic [15:0] nxt(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int cell_x(input logic [15:0] v);
        return (int'(v) % 64) * 10;
    endfunction

    function automatic int cell_y(input logic [15:0] v);
        int c;
        c = (int'(v) / 64) % 64;
        return (c >= 48 ? c - 48 : c) * 10;
    endfunction

    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : nxt(m_lfsr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            chk("apple_x", 32'(ax), exp_ax);
            chk("apple_y", 32'(ay), exp_ay);
            chk("apple_valid", 32'(valid), 32'(exp_valid));
            chk("query_req", 32'(req), 32'(exp_req));
            chk("spawn_done", 32'(done), 32'(exp_done));
            chk("spawn_fail", 32'(fail), 32'(exp_fail));
            if (req) begin
                chk("query_x", 32'(qx), exp_qx);
                chk("query_y", 32'(qy), exp_qy);
            end
            chk("apple_on_grid", 32'(ax % 10 == 0 && ax <= 630 && ay % 10 == 0 && ay <= 470), 1);
            if (req && !req_d) rises++;
        end
        req_d = req;
    end

    task automatic do_reset(input bit with_eaten);
        rst = 1'b1;
        eaten = with_eaten;
        tick;
        exp_ax = 320; exp_ay = 240; exp_valid = 1'b1;
        exp_req = 1'b0; exp_done = 1'b0; exp_fail = 1'b0;
        chk_en = 1'b1;
        chk("reset_lfsr", 32'(dut.r_lfsr), 32'hACE1);
        tick;
        rst = 1'b0;
        eaten = 1'b0;
    endtask

    // nhit: number of leading acks answered with hit; d: cycles before each ack
    task automatic spawn(input int nhit, input int d, input bit stray, input int exp_q);
        int tries, cx, cy, r0;
        bit h;
        tries = 0;
        r0 = rises;
        eaten = 1'b1;
        tick;
        eaten = 1'b0;
        exp_valid = 1'b0;
        do begin
            cx = cell_x(m_lfsr);
            cy = cell_y(m_lfsr);
            tries++;
            tick;
            exp_req = 1'b1; exp_qx = cx; exp_qy = cy;
            for (int i = 0; i < d; i++) begin
                if (stray) begin
                    eaten = (i == 1);
                    hit = (i == 2);
                end
                tick;
            end
            eaten = 1'b0;
            h = tries <= nhit;
            ack = 1'b1;
            hit = h;
            tick;
            ack = 1'b0;
            hit = 1'b0;
            exp_req = 1'b0;
        end while (h && tries < 8);
        exp_ax = cx; exp_ay = cy; exp_valid = 1'b1;
        exp_done = 1'b1; exp_fail = h;
        tick;
        exp_done = 1'b0; exp_fail = 1'b0;
        chk("query_count", 32'(rises - r0), 32'(exp_q));
    endtask

    initial begin
        do_reset(1'b0);
        chk("reset_apple_x", 32'(ax), 320);
        chk("reset_apple_y", 32'(ay), 240);
        chk("reset_valid", 32'(valid), 1);
        chk("reset_req", 32'(req), 0);
        chk("reset_done", 32'(done), 0);

        spawn(0, 3, 1'b0, 1);
        chk("first_spawn_x", 32'(ax), 480);
        chk("first_spawn_y", 32'(ay), 90);

        repeat (3) tick;
        spawn(3, 2, 1'b0, 4);
        repeat (2) tick;
        spawn(8, 1, 1'b0, 8);

        repeat (5) tick;
        spawn(0, 50, 1'b1, 1);

        ack = 1'b1; hit = 1'b1;
        tick;
        ack = 1'b0; hit = 1'b0;
        repeat (3) tick;

        eaten = 1'b1;
        tick;
        eaten = 1'b0;
        exp_valid = 1'b0;
        exp_qx = cell_x(m_lfsr);
        exp_qy = cell_y(m_lfsr);
        tick;
        exp_req = 1'b1;
        tick;
        do_reset(1'b1);
        chk("midq_reset_x", 32'(ax), 320);
        chk("midq_reset_req", 32'(req), 0);
        repeat (2) tick;
        spawn(1, 2, 1'b0, 2);

        repeat (3) tick;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
